// File: rtl/instr_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_responder_pkg : shared state encoding, constants, address check
// Revision: 1.0
// ============================================================================
package instr_fetch_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  // Range test uses the whole word index so high address bits can never alias.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// instr_mem_array : word store, one write port, one registered read port
// Revision: 1.0
// ============================================================================
module instr_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Same-edge write and read of one index returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_responder.sv
`default_nettype none
// ============================================================================
// instr_fetch_responder : fixed-latency instruction fetch responder with load port
// Revision: 1.0
// ============================================================================
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_error,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned IDX_LSB  = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic DIRECT = (LATENCY == 1);

  state_t           r_state;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_ok;

  logic        w_enter_resp;
  logic [31:0] w_fetch_addr;
  logic        w_fetch_err;
  logic        w_load_ok;
  logic [31:0] w_rd_data;
  logic        unused_load_lsb;

  // With LATENCY==1 the accepting edge is also the edge that samples the store.
  assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == '0)) ||
                        (DIRECT && req_ready && req_valid);
  assign w_fetch_addr = (r_state == ST_WAIT) ? r_addr : req_addr;
  assign w_fetch_err  = addr_error(w_fetch_addr, DEPTH_WORDS);
  assign w_load_ok    = load_en && !addr_error({load_addr[31:2], 2'b00}, DEPTH_WORDS);
  assign unused_load_lsb = ^load_addr[1:0];

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_load_ok),
    .wr_idx  (load_addr[IDX_LSB +: AW]),
    .wr_data (load_data),
    .rd_en   (w_enter_resp && !w_fetch_err),
    .rd_idx  (w_fetch_addr[IDX_LSB +: AW]),
    .rd_data (w_rd_data)
  );

  // Read register holds across idle cycles; r_rd_ok forces NOP after reset or error.
  assign resp_instr = r_rd_ok ? w_rd_data : NOP_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rd_ok    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_error <= 1'b0;
    end else if (w_enter_resp) begin
      r_state    <= ST_RESP;
      r_addr     <= w_fetch_addr;
      r_rd_ok    <= !w_fetch_err;
      req_ready  <= 1'b1;
      resp_valid <= 1'b1;
      resp_addr  <= w_fetch_addr;
      resp_error <= w_fetch_err;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_WAIT: r_cnt <= r_cnt - CNT_W'(1);
        default: begin
          if (req_valid) begin
            r_addr    <= req_addr;
            r_cnt     <= CNT_LOAD;
            r_state   <= ST_WAIT;
            req_ready <= 1'b0;
          end else begin
            r_state   <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
